rr_arbiter4: RTL and testbench

Four-requester round-robin arbiter with hold and timeout. Registers one winner at a time and presents it as a 2-bit index plus a valid strobe. It sits directly upstream of the 2-to-4 one-hot decoder: `gnt_idx` drives the decoder's `in` and `gnt_vld` drives its `en`. Consumers must qualify the decoded one-hot with `gnt_vld`, because the decoder emits `4'b1000` when disabled.

---
 rtl/k2_pkg.sv | 11 +
 rtl/rr_pick4.sv | 26 ++
 rtl/rr_arbiter4.sv | 91 +++++++++
 tb/tb_rr_arbiter4.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/k2_pkg.sv
// Shared types and constants for the round-robin arbiter slice.
package k2_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int unsigned N_REQ = 4;

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first set request bit at or after ptr, modulo 4.
module rr_pick4
    import k2_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic [1:0]       win_idx,
    output logic             any
);

    logic [1:0] cand;

    always_comb begin
        win_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = ptr + 2'(i);
            if (!any && req[cand]) begin
                win_idx = cand;
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant hold and optional timeout release.
module rr_arbiter4
    import k2_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [1:0]       gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    arb_state_t       state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [1:0]       gnt_idx_q, gnt_idx_d;
    logic             timeout_q, timeout_d;

    logic [1:0] win_idx;
    logic       win_any;
    logic       rel_withdraw;
    logic       rel_done;
    logic       rel_timeout;

    rr_pick4 u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .win_idx (win_idx),
        .any     (win_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            gnt_idx_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_idx_q <= gnt_idx_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_idx_d = gnt_idx_q;
        timeout_d = 1'b0;

        rel_withdraw = ~req[gnt_idx_q];
        rel_done     = done;
        rel_timeout  = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

        unique case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d   = GRANT;
                    gnt_idx_d = win_idx;
                    hold_d    = '0;
                end
            end
            GRANT: begin
                if (rel_withdraw || rel_done || rel_timeout) begin
                    state_d = IDLE;
                    ptr_d   = gnt_idx_q + 2'd1;
                    // Timeout flags only when it is the sole reason for release.
                    timeout_d = rel_timeout && !rel_withdraw && !rel_done;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = (state_q == GRANT);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 with hand-computed expectations.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    logic [3:0] req0;
    logic       done0;
    logic [1:0] gnt_idx0;
    logic       gnt_vld0;
    logic       timeout0;

    int unsigned vectors = 0;
    int unsigned errs    = 0;

    rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(3)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    rr_arbiter4 #(.MAX_HOLD(0), .CNT_W(2)) u_dut_nto (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req0),
        .done    (done0),
        .gnt_idx (gnt_idx0),
        .gnt_vld (gnt_vld0),
        .timeout (timeout0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic vld, input logic [1:0] idx, input logic to);
        chk({tag, ".vld"}, {3'b0, gnt_vld}, {3'b0, vld});
        chk({tag, ".idx"}, {2'b0, gnt_idx}, {2'b0, idx});
        chk({tag, ".to"},  {3'b0, timeout}, {3'b0, to});
    endtask

    initial begin
        logic [1:0] rot_exp [5];
        rot_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst_n = 1'b0; req = '0; done = 1'b0; req0 = '0; done0 = 1'b0;
        tick(); tick();
        chk_out("reset", 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;

        // Single request, then withdraw (ptr -> 3)
        req = 4'b0100; tick();
        chk_out("single_grant", 1'b1, 2'd2, 1'b0);
        tick();
        chk_out("single_hold", 1'b1, 2'd2, 1'b0);
        req = 4'b0000; tick();
        chk_out("single_release", 1'b0, 2'd2, 1'b0);

        // Wrap: ptr=3, req 1001 -> 3, then 0
        req = 4'b1001; tick();
        chk_out("wrap_first", 1'b1, 2'd3, 1'b0);
        done = 1'b1; tick(); done = 1'b0;
        chk_out("wrap_release", 1'b0, 2'd3, 1'b0);
        tick();
        chk_out("wrap_second", 1'b1, 2'd0, 1'b0);
        done = 1'b1; tick(); done = 1'b0;
        chk_out("wrap_second_rel", 1'b0, 2'd0, 1'b0);
        req = 4'b0000; tick();
        chk_out("wrap_idle", 1'b0, 2'd0, 1'b0);

        // Rotation from ptr=0 with done on each first grant cycle
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_out($sformatf("rot_grant%0d", k), 1'b1, rot_exp[k], 1'b0);
            done = 1'b1; tick(); done = 1'b0;
            chk_out($sformatf("rot_bubble%0d", k), 1'b0, rot_exp[k], 1'b0);
        end
        req = 4'b0000; tick();
        chk_out("rot_idle", 1'b0, 2'd0, 1'b0);

        // Timeout with MAX_HOLD=4 (ptr=1)
        req = 4'b0010; tick();
        chk_out("to_c1", 1'b1, 2'd1, 1'b0);
        tick(); chk_out("to_c2", 1'b1, 2'd1, 1'b0);
        tick(); chk_out("to_c3", 1'b1, 2'd1, 1'b0);
        tick(); chk_out("to_c4", 1'b1, 2'd1, 1'b0);
        tick(); chk_out("to_pulse", 1'b0, 2'd1, 1'b1);
        tick(); chk_out("to_regrant", 1'b1, 2'd1, 1'b0);

        // Reset mid-grant, then resume
        rst_n = 1'b0; tick();
        chk_out("rst_mid", 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1; tick();
        chk_out("rst_resume", 1'b1, 2'd1, 1'b0);
        req = 4'b0000; tick();
        chk_out("rst_release", 1'b0, 2'd1, 1'b0);

        // All requesting with ptr=2 -> winner 2
        req = 4'b1111; tick();
        chk_out("all_ptr2", 1'b1, 2'd2, 1'b0);
        req = 4'b0000; tick();
        chk_out("all_release", 1'b0, 2'd2, 1'b0);

        // done in IDLE ignored
        done = 1'b1; tick(); done = 1'b0;
        chk_out("done_idle", 1'b0, 2'd2, 1'b0);

        // Grant to 0 (ptr=3); req[3] arriving mid-grant is ignored
        req = 4'b0001; tick();
        chk_out("g0", 1'b1, 2'd0, 1'b0);
        req = 4'b1001; tick();
        chk_out("g0_req3", 1'b1, 2'd0, 1'b0);
        req = 4'b1000; tick();
        chk_out("g0_withdraw", 1'b0, 2'd0, 1'b0);
        tick();
        chk_out("g3", 1'b1, 2'd3, 1'b0);

        // Withdraw on the timeout cycle: no timeout pulse
        tick(); tick(); tick();
        chk_out("g3_c4", 1'b1, 2'd3, 1'b0);
        req = 4'b0000; tick();
        chk_out("wd_vs_to", 1'b0, 2'd3, 1'b0);

        // done on the timeout cycle: no timeout pulse (ptr=0)
        req = 4'b0100; tick();
        chk_out("g2", 1'b1, 2'd2, 1'b0);
        tick(); tick(); tick();
        done = 1'b1; tick(); done = 1'b0;
        chk_out("done_vs_to", 1'b0, 2'd2, 1'b0);
        req = 4'b0000; tick();

        // MAX_HOLD=0: grant is never force-released
        req0 = 4'b0001; tick();
        chk("nto_grant.vld", {3'b0, gnt_vld0}, 4'd1);
        chk("nto_grant.idx", {2'b0, gnt_idx0}, 4'd0);
        repeat (10) tick();
        chk("nto_long.vld", {3'b0, gnt_vld0}, 4'd1);
        chk("nto_long.to",  {3'b0, timeout0}, 4'd0);
        req0 = 4'b0000; tick();
        chk("nto_release.vld", {3'b0, gnt_vld0}, 4'd0);
        chk("nto_release.to",  {3'b0, timeout0}, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
